// File: rtl/rs232_pkg.sv
// rs232_pkg -- constants and types shared by the RS232 receiver and transmitter.
//   DATA_BITS         payload bits per frame
//   FRAME_BITS        start + data + slot 9 + stop
//   CLKS_PER_BIT_SIM  bit period used in simulation
//   CLKS_PER_BIT_HW   bit period for 9600 bps at 143 MHz
//   rx_state_e        receiver FSM states
package rs232_pkg;
  localparam int DATA_BITS        = 8;
  localparam int FRAME_BITS       = 11;
  localparam int CLKS_PER_BIT_SIM = 12;
  localparam int CLKS_PER_BIT_HW  = 14881;

  typedef enum logic [2:0] {
    WAIT_HIGH,
    IDLE,
    START,
    DATA,
    TRAIL
  } rx_state_e;
endpackage

// File: rtl/rx_rs232_if.sv
// rx_rs232_if -- serial line in, byte-level results out.
//   iRX     serial line, idle high
//   oDATA   last good byte
//   oVALID  1-cycle pulse, oDATA updated
//   oFERR   1-cycle pulse, frame rejected
//   oBUSY   receiver inside a frame
// master: the receiver; slave: the line driver / byte consumer.
interface rx_rs232_if;
  logic                              iRX;
  logic [rs232_pkg::DATA_BITS-1:0]   oDATA;
  logic                              oVALID;
  logic                              oFERR;
  logic                              oBUSY;

  modport master (input iRX, output oDATA, oVALID, oFERR, oBUSY);
  modport slave  (output iRX, input oDATA, oVALID, oFERR, oBUSY);
endinterface

// File: rtl/rs232_sync.sv
// rs232_sync -- two-flop synchronizer for the asynchronous serial line.
//   clk_s   system clock
//   rstn_s  async active-low reset; both flops reset to 1 (line idle)
//   i_d     asynchronous input
//   o_q     synchronized output
module rs232_sync (
  input  logic clk_s,
  input  logic rstn_s,
  input  logic i_d,
  output logic o_q
);
  logic r_meta;

  always_ff @(posedge clk_s or negedge rstn_s) begin
    if (!rstn_s) begin
      r_meta <= 1'b1;
      o_q    <= 1'b1;
    end else begin
      r_meta <= i_d;
      o_q    <= r_meta;
    end
  end
endmodule

// File: rtl/rx_rs232.sv
// rx_rs232 -- RS232 byte receiver. Frame: start(0), D0..D7 LSB first,
// slot 9 (must be 1), stop (must be 1). Bits are sampled mid-period.
//   clk_s   system clock
//   rstn_s  async active-low reset
//   bus     rx_rs232_if.master: iRX in; oDATA/oVALID/oFERR/oBUSY out
module rx_rs232
  import rs232_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_SIM
) (
  input  logic          clk_s,
  input  logic          rstn_s,
  rx_rs232_if.master    bus
);
  localparam int HALF = CLKS_PER_BIT / 2;
  localparam int CW   = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] CNT_LAST  = CW'(CLKS_PER_BIT - 1);
  // The IDLE->START edge is the first count of the half period, so the
  // start-bit sample lands HALF-1 edges after T0.
  localparam logic [CW-1:0] CNT_HALF  = CW'(HALF - 2);
  localparam logic [3:0]    DATA_LAST = 4'(DATA_BITS - 1);
  localparam logic [3:0]    STOP_IDX  = 4'(FRAME_BITS - DATA_BITS - 2);

  logic                 w_rx_s;
  rx_state_e            r_state, w_state_nxt;
  logic [CW-1:0]        r_cnt;
  logic [3:0]           r_bitn;
  logic [DATA_BITS-1:0] r_shreg;
  logic                 r_slot9;
  logic [DATA_BITS-1:0] r_data;
  logic                 r_valid, r_ferr;
  logic [1:0]           r_arm;
  logic                 w_tick, w_stop_tick, w_valid_d, w_ferr_d, w_busy;

  rs232_sync u_sync (
    .clk_s  (clk_s),
    .rstn_s (rstn_s),
    .i_d    (bus.iRX),
    .o_q    (w_rx_s)
  );

  // The synchronizer holds its reset value (1) for two edges after release;
  // without this the FSM would take that stale 1 as a high line and leave
  // WAIT_HIGH even though iRX is still low.
  always_ff @(posedge clk_s or negedge rstn_s) begin
    if (!rstn_s) r_arm <= 2'b00;
    else         r_arm <= {r_arm[0], 1'b1};
  end

  // Sample point of the current bit.
  assign w_tick = ((r_state == START) && (r_cnt == CNT_HALF)) ||
                  (((r_state == DATA) || (r_state == TRAIL)) && (r_cnt == CNT_LAST));

  // State register
  always_ff @(posedge clk_s or negedge rstn_s) begin
    if (!rstn_s) r_state <= WAIT_HIGH;
    else         r_state <= w_state_nxt;
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      WAIT_HIGH: if (r_arm[1] && w_rx_s) w_state_nxt = IDLE;
      IDLE:      if (!w_rx_s)            w_state_nxt = START;
      START:     if (w_tick)             w_state_nxt = w_rx_s ? IDLE : DATA;
      DATA:      if (w_tick && (r_bitn == DATA_LAST)) w_state_nxt = TRAIL;
      // Stop bit low means the line may be in a break: wait for it to go high.
      TRAIL:     if (w_tick && (r_bitn == STOP_IDX))  w_state_nxt = w_rx_s ? IDLE : WAIT_HIGH;
      default:   w_state_nxt = WAIT_HIGH;
    endcase
  end

  // Output decode
  always_comb begin
    w_busy      = (r_state == START) || (r_state == DATA) || (r_state == TRAIL);
    w_stop_tick = (r_state == TRAIL) && w_tick && (r_bitn == STOP_IDX);
    w_valid_d   = w_stop_tick && w_rx_s && r_slot9;
    w_ferr_d    = w_stop_tick && !(w_rx_s && r_slot9);
  end

  // Counters, shift register and output registers
  always_ff @(posedge clk_s or negedge rstn_s) begin
    if (!rstn_s) begin
      r_cnt   <= '0;
      r_bitn  <= '0;
      r_shreg <= '0;
      r_slot9 <= 1'b1;
      r_data  <= '0;
      r_valid <= 1'b0;
      r_ferr  <= 1'b0;
    end else begin
      r_valid <= w_valid_d;
      r_ferr  <= w_ferr_d;
      if (w_valid_d) r_data <= r_shreg;
      case (r_state)
        START, DATA, TRAIL: begin
          r_cnt <= w_tick ? '0 : r_cnt + 1'b1;
          if (w_tick && (r_state == DATA)) begin
            r_shreg[r_bitn[2:0]] <= w_rx_s;
            r_bitn <= (r_bitn == DATA_LAST) ? 4'd0 : r_bitn + 4'd1;
          end
          if (w_tick && (r_state == TRAIL)) begin
            if (r_bitn == 4'd0) r_slot9 <= w_rx_s;
            r_bitn <= (r_bitn == STOP_IDX) ? 4'd0 : r_bitn + 4'd1;
          end
        end
        default: begin
          r_cnt  <= '0;
          r_bitn <= '0;
        end
      endcase
    end
  end

  assign bus.oDATA  = r_data;
  assign bus.oVALID = r_valid;
  assign bus.oFERR  = r_ferr;
  assign bus.oBUSY  = w_busy;
endmodule

// File: tb/tb_rx_rs232.sv
// tb_rx_rs232 -- scoreboard bench for rx_rs232 at 12 clocks per bit.
module tb_rx_rs232;
  localparam int CPB = 12;
  localparam int LAT = 128;   // falling edge E to result pulse

  typedef struct { bit valid; logic [7:0] data; int cyc; } exp_t;
  typedef struct { int cyc; bit busy; } probe_t;

  logic clk_s, rstn_s;
  int   cyc = 0;
  int   n_chk = 0, n_fail = 0;
  exp_t   sb[$];
  probe_t busy_q[$];
  logic [7:0] last_good = 8'h00;

  rx_rs232_if bus();
  rx_rs232 #(.CLKS_PER_BIT(CPB)) dut (.clk_s(clk_s), .rstn_s(rstn_s), .bus(bus));

  initial clk_s = 1'b0;
  always #5 clk_s = ~clk_s;
  always @(posedge clk_s) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s @cyc %0d: got %0h expected %0h", tag, cyc, got, exp);
    end
  endtask

  task automatic probe(input int c, input bit b);
    busy_q.push_back('{c, b});
  endtask

  // All drive tasks start and end exactly at a rising edge.
  task automatic idle(input int n);
    #1 bus.iRX = 1'b1;
    repeat (n) @(posedge clk_s);
  endtask

  task automatic send_frame(input logic [7:0] b, input bit s9, input bit stp);
    logic [10:0] f;
    int e;
    f = {stp, s9, b, 1'b0};
    #1 bus.iRX = f[0];
    e = cyc;
    if (s9 && stp) begin
      sb.push_back('{1'b1, b, e + LAT});
      last_good = b;
    end else begin
      sb.push_back('{1'b0, last_good, e + LAT});
    end
    probe(e + 2, 1'b0); probe(e + 3, 1'b1); probe(e + LAT - 1, 1'b1); probe(e + LAT, 1'b0);
    repeat (CPB) @(posedge clk_s);
    for (int i = 1; i < 11; i++) begin
      #1 bus.iRX = f[i];
      repeat (CPB) @(posedge clk_s);
    end
  endtask

  // Monitor: pop the scoreboard on every result pulse, check busy probes.
  logic [1:0] pulse;
  bit         prev_pulse = 1'b0;
  exp_t       ex;
  always @(negedge clk_s) begin
    if (rstn_s) begin
      pulse = {bus.oVALID, bus.oFERR};
      if (prev_pulse) chk("one_cycle_pulse", pulse, 2'b00);
      else if (pulse != 2'b00) begin
        if (sb.size() == 0) chk("unexpected_pulse", pulse, 2'b00);
        else begin
          ex = sb.pop_front();
          chk("pulse_kind", pulse, ex.valid ? 2'b10 : 2'b01);
          chk("pulse_cycle", cyc, ex.cyc);
          chk("odata", bus.oDATA, ex.data);
        end
      end
      prev_pulse = (pulse != 2'b00);
    end else prev_pulse = 1'b0;
    if (busy_q.size() > 0 && cyc >= busy_q[0].cyc) begin
      chk($sformatf("obusy@%0d", busy_q[0].cyc), bus.oBUSY, busy_q[0].busy);
      void'(busy_q.pop_front());
    end
  end

  initial begin
    logic [10:0] f;
    int e;
    bus.iRX = 1'b1;
    rstn_s  = 1'b0;
    repeat (3) @(posedge clk_s);
    @(negedge clk_s);
    chk("rst_odata", bus.oDATA, 8'h00);
    chk("rst_ovalid", bus.oVALID, 1'b0);
    chk("rst_oferr", bus.oFERR, 1'b0);
    chk("rst_obusy", bus.oBUSY, 1'b0);
    @(posedge clk_s);
    #1 rstn_s = 1'b1;
    @(posedge clk_s);
    idle(6);

    // 1: single good byte
    send_frame(8'hA5, 1'b1, 1'b1);
    idle(20);

    // 2: back-to-back bytes, one stop bit
    send_frame(8'h00, 1'b1, 1'b1);
    send_frame(8'hFF, 1'b1, 1'b1);
    send_frame(8'h3C, 1'b1, 1'b1);
    idle(20);

    // 3: 3-cycle low glitch is rejected by the start check
    #1 bus.iRX = 1'b0;
    e = cyc;
    probe(e + 3, 1'b1); probe(e + 9, 1'b0);
    repeat (3) @(posedge clk_s);
    idle(30);
    send_frame(8'h5A, 1'b1, 1'b1);
    idle(20);

    // 4: stop bit 0 then line held low: framing error, no restart while low
    e = cyc + 1;
    send_frame(8'h81, 1'b1, 1'b0);
    probe(e + 150, 1'b0); probe(e + 170, 1'b0);
    repeat (40) @(posedge clk_s);
    idle(30);
    send_frame(8'h42, 1'b1, 1'b1);
    idle(20);

    // 5: slot 9 = 0, stop 1: framing error, receiver goes straight to IDLE
    send_frame(8'h81, 1'b0, 1'b1);
    send_frame(8'h99, 1'b1, 1'b1);
    idle(20);

    // 6: reset during data bit 4 of 8'hC3, line low through release
    f = {1'b1, 1'b1, 8'hC3, 1'b0};
    for (int i = 0; i < 5; i++) begin
      #1 bus.iRX = f[i];
      repeat (CPB) @(posedge clk_s);
    end
    #1 bus.iRX = f[5];
    repeat (6) @(posedge clk_s);
    #1 rstn_s = 1'b0;
    last_good = 8'h00;
    @(negedge clk_s);
    chk("midrst_odata", bus.oDATA, 8'h00);
    chk("midrst_ovalid", bus.oVALID, 1'b0);
    chk("midrst_oferr", bus.oFERR, 1'b0);
    chk("midrst_obusy", bus.oBUSY, 1'b0);
    bus.iRX = 1'b0;
    repeat (2) @(posedge clk_s);
    #1 rstn_s = 1'b1;
    probe(cyc + 5, 1'b0); probe(cyc + 20, 1'b0); probe(cyc + 39, 1'b0);
    repeat (40) @(posedge clk_s);
    idle(30);
    send_frame(8'h96, 1'b1, 1'b1);

    for (int i = 0; i < 400 && (sb.size() != 0 || busy_q.size() != 0); i++)
      @(posedge clk_s);
    chk("scoreboard_drained", sb.size(), 0);
    chk("probes_drained", busy_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
